// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = byte source / memory side.
interface instr_mem_loader_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: 16-bit length header, then MSB-first 32-bit words written at BASE_ADDR+n.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h06F0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_mem_loader_if.master    bus,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    LOAD,
    WRITE,
    DONE,
    ERR
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  // After the last word (or an empty image) the load ends here.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = DONE;
`endif

  localparam logic [16:0] LEN_MAX = 17'(2 ** ADDR_WIDTH);

  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [1:0]            idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] asm_reg, asm_next;
  logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;
  logic [31:0]           wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_reg, csum_next;
`endif

  logic byte_ready_c;
  logic xfer;

  always_comb begin
    byte_ready_c = 1'b0;
    case (state_reg)
      HDR_HI, HDR_LO, LOAD: byte_ready_c = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:                  byte_ready_c = 1'b1;
`endif
      default:              byte_ready_c = 1'b0;
    endcase
  end

  assign xfer = bus.byte_valid && byte_ready_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      idx_reg     <= '0;
      asm_reg     <= '0;
      cnt_reg     <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      asm_reg     <= asm_next;
      cnt_reg     <= cnt_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
`ifdef LOADER_CHECKSUM_EN
      csum_reg    <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    asm_next     = asm_reg;
    cnt_next     = cnt_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
`ifdef LOADER_CHECKSUM_EN
    csum_next    = csum_reg;
`endif

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = HDR_HI;
          cnt_next   = '0;
          idx_next   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = '0;
`endif
        end
      end

      HDR_HI: begin
        if (xfer) begin
          len_next[15:8] = bus.byte_in;
          state_next     = HDR_LO;
        end
      end

      HDR_LO: begin
        if (xfer) begin
          len_next[7:0] = bus.byte_in;
          idx_next      = '0;
          if (len_next == 16'd0)
            state_next = END_STATE;
          else if ({1'b0, len_next} > LEN_MAX)
            state_next = ERR;
          else
            state_next = LOAD;
        end
      end

      LOAD: begin
        if (xfer) begin
          asm_next = {asm_reg[DATA_WIDTH-9:0], bus.byte_in};
`ifdef LOADER_CHECKSUM_EN
          csum_next = csum_reg ^ bus.byte_in;
`endif
          if (idx_reg == 2'd3) begin
            // Capture the write port now so it is valid for the whole WRITE cycle.
            idx_next     = '0;
            wr_addr_next = BASE_ADDR + 32'(cnt_reg);
            wr_data_next = asm_next;
            state_next   = WRITE;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end

      WRITE: begin
        cnt_next = cnt_reg + 1'b1;
        if (32'(cnt_next) == 32'(len_reg))
          state_next = END_STATE;
        else
          state_next = LOAD;
      end

`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer)
          state_next = (bus.byte_in == csum_reg) ? DONE : ERR;
      end
`endif

      default: state_next = IDLE;
    endcase
  end

  assign bus.byte_ready = byte_ready_c;
  assign bus.wr_en      = (state_reg == WRITE);
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign word_cnt       = cnt_reg;
  assign done           = (state_reg == DONE);
  assign error          = (state_reg == ERR);
  // The CPU runs only when no load is in progress and the last one did not fail.
  assign cpu_hold       = !((state_reg == IDLE) || (state_reg == DONE));

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected writes, a negedge monitor checks them.
// Adds a checksum byte to every load and runs the checksum tests when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_cnt;
  logic        cpu_hold, done, error;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];
  logic [31:0] words_q[$];

  instr_mem_loader_if #(.DATA_WIDTH(32)) bus ();

  instr_mem_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .BASE_ADDR (32'h06F0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .word_cnt (word_cnt),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.wr_en === 1'b1) begin
      $display("write addr=%08h data=%08h word_cnt=%0d", bus.wr_addr, bus.wr_data, word_cnt);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%08h:%08h expected=none", bus.wr_addr, bus.wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e[63:32]));
        check("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
      end
      check("byte_ready_in_write", 64'(bus.byte_ready), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout actual=0 expected=1");
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Sends up to n bytes from the front of stim; gapped mode idles i%3 cycles before byte i.
  task automatic send_n(input int n, input bit gapped);
    for (int i = 0; i < n && stim.size() > 0; i++) begin
      send_byte(stim.pop_front(), gapped ? (i % 3) : 0);
    end
  endtask

  // Builds header + words_q payload (+ checksum), queuing the expected writes.
  task automatic queue_load(input logic [15:0] len);
    logic [7:0] x;
    x = 8'h00;
    stim.push_back(len[15:8]);
    stim.push_back(len[7:0]);
    for (int i = 0; i < words_q.size(); i++) begin
      logic [31:0] w;
      w = words_q[i];
      exp_q.push_back({32'h06F0 + 32'(i), w});
      for (int k = 3; k >= 0; k--) begin
        stim.push_back(w[k*8 +: 8]);
        x = x ^ w[k*8 +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
    words_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL end_timeout actual=busy expected=done_or_error");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_wr_en"},      64'(bus.wr_en),      64'd0);
    check({tag, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
    check({tag, "_wr_data"},    64'(bus.wr_data),    64'd0);
    check({tag, "_word_cnt"},   64'(word_cnt),       64'd0);
    check({tag, "_cpu_hold"},   64'(cpu_hold),       64'd0);
    check({tag, "_done"},       64'(done),           64'd0);
    check({tag, "_error"},      64'(error),          64'd0);
  endtask

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset
    rst = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // 1: single word
    words_q.push_back(32'hDEADBEEF);
    queue_load(16'd1);
    pulse_start();
    check("t1_cpu_hold_loading", 64'(cpu_hold), 64'd1);
    send_n(stim.size(), 1'b0);
    wait_end();
    check("t1_done", 64'(done), 64'd1);
    check("t1_error", 64'(error), 64'd0);
    check("t1_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t1_word_cnt", 64'(word_cnt), 64'd1);

    // 2: three words with byte_valid gaps, including mid-word
    words_q.push_back(32'h11223344);
    words_q.push_back(32'h55667788);
    words_q.push_back(32'h99AABBCC);
    queue_load(16'd3);
    pulse_start();
    send_n(stim.size(), 1'b1);
    wait_end();
    check("t2_done", 64'(done), 64'd1);
    check("t2_word_cnt", 64'(word_cnt), 64'd3);

    // 3a: empty image
    queue_load(16'd0);
    pulse_start();
    send_n(stim.size(), 1'b0);
    wait_end();
    check("t3_empty_done", 64'(done), 64'd1);
    check("t3_empty_word_cnt", 64'(word_cnt), 64'd0);
    check("t3_empty_cpu_hold", 64'(cpu_hold), 64'd0);

    // 3b: oversize length 0x0401
    stim.push_back(8'h04);
    stim.push_back(8'h01);
    pulse_start();
    send_n(stim.size(), 1'b0);
    wait_end();
    repeat (3) tick();
    check("t3_big_error", 64'(error), 64'd1);
    check("t3_big_done", 64'(done), 64'd0);
    check("t3_big_cpu_hold", 64'(cpu_hold), 64'd1);
    check("t3_big_byte_ready", 64'(bus.byte_ready), 64'd0);
    pulse_start();
    check("t3_restart_error", 64'(error), 64'd0);
    check("t3_restart_cpu_hold", 64'(cpu_hold), 64'd1);

    // 4: start pulsed during 2nd word is ignored (load already begun by 3b restart)
    words_q.push_back(32'hA1B2C3D4);
    words_q.push_back(32'h0BADF00D);
    queue_load(16'd2);
    send_n(8, 1'b0);
    pulse_start();
    check("t4_hold_after_start", 64'(cpu_hold), 64'd1);
    send_n(stim.size(), 1'b0);
    wait_end();
    check("t4_done", 64'(done), 64'd1);
    check("t4_word_cnt", 64'(word_cnt), 64'd2);

    // 5: reset after 2 bytes of word 1, then a fresh load
    stim.push_back(8'h00);
    stim.push_back(8'h02);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    pulse_start();
    send_n(stim.size(), 1'b0);
    rst = 1'b0;
    tick();
    check_all_zero("midload_reset");
    rst = 1'b1;
    tick();
    words_q.push_back(32'hCAFEF00D);
    queue_load(16'd1);
    pulse_start();
    send_n(stim.size(), 1'b0);
    wait_end();
    check("t5_done", 64'(done), 64'd1);
    check("t5_word_cnt", 64'(word_cnt), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back({32'h000006F0, 32'h01020304});
      stim.push_back(8'h00);
      stim.push_back(8'h01);
      stim.push_back(8'h01);
      stim.push_back(8'h02);
      stim.push_back(8'h03);
      stim.push_back(8'h04);
      stim.push_back(pass == 0 ? 8'h04 : 8'h05);
      pulse_start();
      send_n(stim.size(), 1'b0);
      wait_end();
      check("t6_done", 64'(done), pass == 0 ? 64'd1 : 64'd0);
      check("t6_error", 64'(error), pass == 0 ? 64'd0 : 64'd1);
      check("t6_cpu_hold", 64'(cpu_hold), pass == 0 ? 64'd0 : 64'd1);
    end
`endif

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: takes a byte stream, assembles 32-bit instruction words and drives a word write port into instruction memory.
- Addresses are in the same program-address space that the fetch path presents on ADDR_Prog, starting at BASE_ADDR (0x06F0).
- Holds the CPU off (cpu_hold) while a program image is being loaded.
- Sits between the host/UART byte source and the instruction memory write port.

Parameters:
DATA_WIDTH, 32, instruction word width; fixed at 4 bytes.
ADDR_WIDTH, 10, instruction memory depth is 2**ADDR_WIDTH words.
BASE_ADDR, 32'h06F0, program address of word 0.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous, active-low.
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
byte_in  in  8  stream byte.
byte_valid  in  1  byte_in is valid.
byte_ready  out  1  loader accepts byte; a transfer occurs when byte_valid && byte_ready.
wr_en  out  1  one-cycle instruction memory write strobe.
wr_addr  out  32  program address = BASE_ADDR + word index.
wr_data  out  DATA_WIDTH  assembled word, first byte received in bits [31:24].
word_cnt  out  ADDR_WIDTH+1  words written so far in the current load.
cpu_hold  out  1  CPU must stall/fetch nothing while 1.
done  out  1  load completed successfully; level signal.
error  out  1  load aborted; level signal.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE. All outputs 0: byte_ready, wr_en, wr_addr, wr_data, word_cnt, cpu_hold, done, error. Internal byte index, length and assembly register are cleared.
- States: IDLE, HDR_HI, HDR_LO, LOAD, WRITE, DONE, ERR.
- IDLE/DONE/ERR:
  - byte_ready=0; incoming bytes are ignored.
  - start -> HDR_HI. On that edge, clear word_cnt, done and error; set cpu_hold=1.
- HDR_HI: byte_ready=1. On transfer, latch len[15:8] -> HDR_LO.
- HDR_LO: byte_ready=1. On transfer, latch len[7:0], then:
  - len==0 -> DONE.
  - len>2**ADDR_WIDTH -> ERR.
  - otherwise -> LOAD with byte index 0.
- LOAD: byte_ready=1. Each transfer shifts the byte into the assembly register (MSB first) and increments the byte index. When the 4th byte is accepted -> WRITE.
- WRITE: exactly one cycle.
  - wr_en=1, wr_addr=BASE_ADDR+word_cnt, wr_data=assembled word; byte_ready=0 (one-cycle bubble per word).
  - On exit, word_cnt increments.
  - If word_cnt+1==len -> DONE, else -> LOAD with byte index 0.
- Write latency: wr_en is asserted in the cycle immediately after the 4th byte handshake. wr_addr and wr_data hold their last values outside WRITE.
- DONE: done=1, cpu_hold=0, until the next start or reset.
- ERR: error=1 and cpu_hold=1 until the next start or reset; no writes occur.
- start while in HDR_HI/HDR_LO/LOAD/WRITE is ignored.
- byte_valid held low mid-word stalls indefinitely with no timeout. The partial word is preserved.
- Reset mid-load: returns to IDLE next edge and cpu_hold drops. Words already written stay in memory; the partial word is discarded.
- Address arithmetic is 32-bit unsigned. The highest legal word is BASE_ADDR+2**ADDR_WIDTH-1 (0x0AEF with defaults).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM goes to a CHK state (byte_ready=1) instead of DONE and accepts one more byte.
  - Required value: XOR of all payload bytes (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - len==0 also passes through CHK, with expected value 0x00.
- Not defined: no CHK state and no trailing byte; behaviour exactly as above.

Test Plan:
1. Reset with rst=0 for 2 cycles, then start; send 00 01 DE AD BE EF -> one wr_en pulse with wr_addr=0x06F0, wr_data=0xDEADBEEF, word_cnt=1, done=1, cpu_hold=0 after the write.
2. len=3 with byte_valid deasserted randomly, including mid-word -> three writes at 0x06F0/0x06F1/0x06F2 with correct data in order; byte_ready=0 in each WRITE cycle; no extra writes.
3. Header 00 00 -> DONE directly with no wr_en; header 04 01 (1025 > 1024) -> error=1, cpu_hold=1, no wr_en; a new start then clears error.
4. Pulse start during LOAD of the 2nd word -> ignored; load completes normally with len words written.
5. rst=0 after 2 of 4 bytes of word 1 -> next cycle all outputs 0 and state IDLE; a fresh load then starts writing at 0x06F0.
6. (LOADER_CHECKSUM_EN) len=1, word 0x01020304, checksum byte 0x04 -> done=1; same load with checksum 0x05 -> error=1.
